// File: rtl/fadd16_align_prep_pipe.sv
// Front of the fp16 adder: unpacks two binary16 operands, orders them by magnitude and
// registers exponent difference, significands, path select and special-case flags.
module fadd16_align_prep_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] opa_i,
  input  logic [15:0] opb_i,
  input  logic        is_sub_i,
  input  logic [2:0]  rm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [4:0]  exp_diff_o,
  output logic        exp_zero_o,
  output logic        do_sub_o,
  output logic [4:0]  exp_large_o,
  output logic [10:0] sig_large_o,
  output logic [10:0] sig_small_o,
  output logic        sign_res_o,
  output logic        eq_mag_o,
  output logic        far_path_o,
  output logic        nan_o,
  output logic        inf_o,
  output logic        nv_o,
  output logic [2:0]  rm_o
);

  function automatic logic is_inf(input logic [14:0] mag);
    return (&mag[14:10]) & ~(|mag[9:0]);
  endfunction

  function automatic logic is_nan(input logic [14:0] mag);
    return (&mag[14:10]) & (|mag[9:0]);
  endfunction

  logic        s1_valid;
  logic [15:0] s1_opa, s1_opb;
  logic        s1_is_sub, s1_a_ge, s1_a_eq;
  logic [2:0]  s1_rm;
  logic        s1_en, s2_en;

  assign s2_en      = ~out_valid_o | out_ready_i;
  assign s1_en      = ~s1_valid | s2_en;
  assign in_ready_o = s1_en & ~flush_i;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_opa    <= '0;
      s1_opb    <= '0;
      s1_is_sub <= 1'b0;
      s1_rm     <= '0;
      s1_a_ge   <= 1'b0;
      s1_a_eq   <= 1'b0;
    end else begin
      if (flush_i)    s1_valid <= 1'b0;
      else if (s1_en) s1_valid <= in_valid_i;
      if (in_valid_i && in_ready_o) begin
        s1_opa    <= opa_i;
        s1_opb    <= opb_i;
        s1_is_sub <= is_sub_i;
        s1_rm     <= rm_i;
        s1_a_ge   <= opa_i[14:0] >= opb_i[14:0];
        s1_a_eq   <= opa_i[14:0] == opb_i[14:0];
      end
    end
  end

  // Stage-2 combinational datapath from the ordered operand pair.
  logic        sign_b_eff, swap, do_sub, both_inf_sub;
  logic [14:0] large_mag, small_mag;
  logic [4:0]  exp_l, exp_s, diff;
  logic        nan, nv, inf;

  assign sign_b_eff   = s1_opb[15] ^ s1_is_sub;
  assign swap         = ~s1_a_ge;
  assign do_sub       = s1_opa[15] ^ sign_b_eff;
  assign large_mag    = swap ? s1_opb[14:0] : s1_opa[14:0];
  assign small_mag    = swap ? s1_opa[14:0] : s1_opb[14:0];
  assign exp_l        = large_mag[14:10];
  assign exp_s        = small_mag[14:10];
  assign diff         = exp_l - exp_s;
  assign both_inf_sub = is_inf(s1_opa[14:0]) & is_inf(s1_opb[14:0]) & do_sub;
  assign nan          = is_nan(s1_opa[14:0]) | is_nan(s1_opb[14:0]) | both_inf_sub;
  assign nv           = (is_nan(s1_opa[14:0]) & ~s1_opa[9]) | (is_nan(s1_opb[14:0]) & ~s1_opb[9])
                      | both_inf_sub;
  assign inf          = (is_inf(s1_opa[14:0]) | is_inf(s1_opb[14:0])) & ~nan;

  // NOTE: data registers are reset too, since outputs must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      exp_diff_o  <= '0;
      exp_zero_o  <= 1'b0;
      do_sub_o    <= 1'b0;
      exp_large_o <= '0;
      sig_large_o <= '0;
      sig_small_o <= '0;
      sign_res_o  <= 1'b0;
      eq_mag_o    <= 1'b0;
      far_path_o  <= 1'b0;
      nan_o       <= 1'b0;
      inf_o       <= 1'b0;
      nv_o        <= 1'b0;
      rm_o        <= '0;
    end else begin
      if (flush_i)    out_valid_o <= 1'b0;
      else if (s2_en) out_valid_o <= s1_valid;
      if (s2_en && s1_valid) begin
        exp_diff_o  <= diff;
        exp_zero_o  <= exp_s == 5'd0;
        do_sub_o    <= do_sub;
        exp_large_o <= exp_l;
        sig_large_o <= {exp_l != 5'd0, large_mag[9:0]};
        sig_small_o <= {exp_s != 5'd0, small_mag[9:0]};
        sign_res_o  <= swap ? sign_b_eff : s1_opa[15];
        eq_mag_o    <= s1_a_eq;
        far_path_o  <= ~do_sub | (diff > 5'd1);
        nan_o       <= nan;
        inf_o       <= inf;
        nv_o        <= nv;
        rm_o        <= s1_rm;
      end
    end
  end

endmodule

// File: tb/tb_fadd16_align_prep_pipe.sv
// Randomized bench for fadd16_align_prep_pipe: integer-level reference model, scoreboard
// queue checked every cycle, plus directed literal cases for the model and handshake.
module tb_fadd16_align_prep_pipe;

  typedef struct packed {
    logic [4:0]  exp_diff;
    logic        exp_zero;
    logic        do_sub;
    logic [4:0]  exp_large;
    logic [10:0] sig_large;
    logic [10:0] sig_small;
    logic        sign_res;
    logic        eq_mag;
    logic        far_path;
    logic        nan;
    logic        inf;
    logic        nv;
    logic [2:0]  rm;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, is_sub = 1'b0;
  logic [15:0] opa = '0, opb = '0;
  logic [2:0]  rm = '0;
  logic        in_ready, out_valid;
  logic [4:0]  exp_diff, exp_large;
  logic        exp_zero, do_sub, sign_res, eq_mag, far_path, nan, inf, nv;
  logic [10:0] sig_large, sig_small;
  logic [2:0]  rm_out;

  int n_checks = 0;
  int n_pass   = 0;
  res_t q[$];

  fadd16_align_prep_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opa_i(opa), .opb_i(opb), .is_sub_i(is_sub), .rm_i(rm), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .exp_diff_o(exp_diff), .exp_zero_o(exp_zero), .do_sub_o(do_sub),
    .exp_large_o(exp_large), .sig_large_o(sig_large), .sig_small_o(sig_small),
    .sign_res_o(sign_res), .eq_mag_o(eq_mag), .far_path_o(far_path), .nan_o(nan),
    .inf_o(inf), .nv_o(nv), .rm_o(rm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic res_t dut_res();
    res_t r;
    r.exp_diff = exp_diff;   r.exp_zero = exp_zero;   r.do_sub = do_sub;
    r.exp_large = exp_large; r.sig_large = sig_large; r.sig_small = sig_small;
    r.sign_res = sign_res;   r.eq_mag = eq_mag;       r.far_path = far_path;
    r.nan = nan;             r.inf = inf;             r.nv = nv;
    r.rm = rm_out;
    return r;
  endfunction

  // Reference: order by integer magnitude, then derive everything from plain field values.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic [2:0] rmode);
    res_t r;
    int ma = int'(a[14:0]);
    int mb = int'(b[14:0]);
    bit sb = b[15] ^ sub;
    bit b_big = mb > ma;
    logic [15:0] l = b_big ? b : a;
    logic [15:0] s = b_big ? a : b;
    int el = int'(l[14:10]);
    int es = int'(s[14:10]);
    bit a_nan = a[14:10] == 5'd31 && a[9:0] != 0;
    bit b_nan = b[14:10] == 5'd31 && b[9:0] != 0;
    bit a_inf = a[14:10] == 5'd31 && a[9:0] == 0;
    bit b_inf = b[14:10] == 5'd31 && b[9:0] == 0;
    bit ii;
    r.do_sub    = a[15] ^ sb;
    r.exp_diff  = 5'(el - es);
    r.exp_zero  = es == 0;
    r.exp_large = 5'(el);
    r.sig_large = {el != 0, l[9:0]};
    r.sig_small = {es != 0, s[9:0]};
    r.sign_res  = b_big ? sb : a[15];
    r.eq_mag    = ma == mb;
    r.far_path  = !r.do_sub || (el - es) > 1;
    ii          = a_inf && b_inf && r.do_sub;
    r.nan       = a_nan || b_nan || ii;
    r.nv        = (a_nan && !a[9]) || (b_nan && !b[9]) || ii;
    r.inf       = (a_inf || b_inf) && !r.nan;
    r.rm        = rmode;
    return r;
  endfunction

  // Scoreboard: runs mid-cycle, when inputs and outputs are both settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      check("in_ready", 64'(in_ready), 64'(!flush && (q.size() < 2 || out_ready)));
      if (out_valid) begin
        if (q.size() == 0) check("spurious_out_valid", 64'(out_valid), 64'(0));
        else check("beat", 64'(dut_res()), 64'(q[0]));
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (flush) q.delete();
      if (in_valid && in_ready) q.push_back(model(opa, opb, is_sub, rm));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat into an idle pipeline with out_ready high; returns when it should be at S2.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic [2:0] rmode);
    opa = a; opb = b; is_sub = sub; rm = rmode; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  function automatic logic [15:0] rand_op();
    logic [4:0] e;
    logic [9:0] m;
    int k = int'($urandom_range(0, 9));
    if (k < 2)      e = 5'd31;
    else if (k < 4) e = 5'd0;
    else if (k < 6) e = 5'(15 + $urandom_range(0, 2));
    else            e = 5'($urandom);
    m = 10'($urandom);
    if ($urandom_range(0, 3) == 0) m = '0;
    return {1'($urandom), e, m};
  endfunction

  logic [15:0] bp_a[4] = '{16'h3C00, 16'h4400, 16'hC200, 16'h0123};
  logic [15:0] bp_b[4] = '{16'h4000, 16'h3C00, 16'h4100, 16'h8456};

  initial begin
    int idx;
    bit acc;
    res_t snap;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_outputs", 64'(dut_res()), 64'(0));
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;

    send(16'h3C00, 16'h4000, 1'b0, 3'd2);
    check("t1_valid", 64'(out_valid), 64'(1));
    check("t1_exp_diff", 64'(exp_diff), 64'(1));
    check("t1_do_sub", 64'(do_sub), 64'(0));
    check("t1_exp_large", 64'(exp_large), 64'(16));
    check("t1_sig_large", 64'(sig_large), 64'(11'h400));
    check("t1_sig_small", 64'(sig_small), 64'(11'h400));
    check("t1_sign_far", 64'({sign_res, far_path}), 64'(2'b01));
    check("t1_rm", 64'(rm_out), 64'(2));

    send(16'h3C00, 16'h3800, 1'b1, 3'd0);
    check("t2_do_sub", 64'(do_sub), 64'(1));
    check("t2_exp_diff", 64'(exp_diff), 64'(1));
    check("t2_far_path", 64'(far_path), 64'(0));
    check("t2_sign_res", 64'(sign_res), 64'(0));
    check("t2_exp_large", 64'(exp_large), 64'(15));

    send(16'h0001, 16'h3C00, 1'b0, 3'd0);
    check("t3_exp_diff", 64'(exp_diff), 64'(15));
    check("t3_exp_zero", 64'(exp_zero), 64'(1));
    check("t3_sig_small", 64'(sig_small), 64'(11'h001));
    check("t3_sig_large", 64'(sig_large), 64'(11'h400));
    check("t3_far_path", 64'(far_path), 64'(1));

    send(16'h7C00, 16'h7C00, 1'b1, 3'd0);
    check("t4_inf_minus_inf", 64'({nan, nv, inf}), 64'(3'b110));
    send(16'h7D00, 16'h3C00, 1'b0, 3'd0);
    check("t5_snan", 64'({nan, nv, inf}), 64'(3'b110));
    send(16'h7C00, 16'h3C00, 1'b0, 3'd0);
    check("t6_inf_plus_one", 64'({nan, nv, inf}), 64'(3'b001));
    send(16'hBC00, 16'h3C00, 1'b0, 3'd0);
    check("t7_eq_mag", 64'({eq_mag, do_sub, far_path}), 64'(3'b110));
    repeat (3) step();

    // Backpressure: four beats offered with the output stalled.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      opa = bp_a[idx]; opb = bp_b[idx]; is_sub = 1'b0; rm = 3'(idx); in_valid = 1'b1;
      if (c == 2) begin
        check("bp_ready_low", 64'(in_ready), 64'(0));
        snap = dut_res();
      end
      acc = in_ready;
      step();
      if (acc) idx++;
    end
    check("bp_accepted_two", 64'(idx), 64'(2));
    check("bp_stable", 64'(dut_res()), 64'(snap));
    check("bp_head_exp_large", 64'(exp_large), 64'(16));
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      opa = bp_a[idx]; opb = bp_b[idx]; rm = 3'(idx); in_valid = 1'b1;
      acc = in_ready;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 64'(idx), 64'(4));
    repeat (4) step();
    check("bp_drained", 64'(q.size()), 64'(0));

    // Flush with two beats in flight; the beat offered during flush must be refused.
    out_ready = 1'b0;
    send(16'h4200, 16'h3C00, 1'b1, 3'd1);
    check("fl_pre_valid", 64'(out_valid), 64'(1));
    opa = 16'h5000; opb = 16'h1000; in_valid = 1'b1;
    step();
    flush = 1'b1;
    check("fl_ready_forced_low", 64'(in_ready), 64'(0));
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid_cleared", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    repeat (3) step();
    check("fl_nothing_emerges", 64'(out_valid), 64'(0));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      opa       = rand_op();
      opb       = ($urandom_range(0, 7) == 0) ? {1'($urandom), opa[14:0]} : rand_op();
      is_sub    = 1'($urandom);
      rm        = 3'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 49) == 0;
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("rand_drained", 64'(q.size()), 64'(0));

    // Asynchronous reset in the middle of a stream.
    in_valid = 1'b1;
    opa = 16'h4A00; opb = 16'h3C00; is_sub = 1'b0; rm = 3'd5;
    repeat (3) step();
    check("rst_pre_valid", 64'(out_valid), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'(0));
    check("rst_async_outputs", 64'(dut_res()), 64'(0));
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("rst_beats_lost", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fadd16_align_prep_pipe.md
Name: fadd16_align_prep_pipe

Overview:
- Two-stage valid/ready pipeline at the front of the fp16 adder. It unpacks two binary16 operands and orders them by magnitude, swapping when needed.
- It computes the raw exponent difference, small-operand denormal flag, effective-subtract flag, near/far path select and special-case flags.
- It registers these outputs for the far-path alignment stage, whose rsh lost-bits mask consumes exp_diff_o, exp_zero_o and do_sub_o directly.

Parameters:
- none

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- flush_i  input  1  synchronous pipeline kill
- in_valid_i  input  1  operand beat valid
- in_ready_o  output  1  stage can accept beat
- opa_i  input  16  fp16 operand A
- opb_i  input  16  fp16 operand B
- is_sub_i  input  1  operation is A-B
- rm_i  input  3  rounding mode, pass-through
- out_valid_o  output  1  result beat valid
- out_ready_i  input  1  downstream accepts
- exp_diff_o  output  5  exp_large - exp_small, raw biased fields
- exp_zero_o  output  1  small operand exponent field == 0
- do_sub_o  output  1  effective subtraction
- exp_large_o  output  5  large operand exponent field
- sig_large_o  output  11  {hidden, mant} of large operand; hidden = (exp != 0)
- sig_small_o  output  11  {hidden, mant} of small operand
- sign_res_o  output  1  result sign before exact-zero fixup
- eq_mag_o  output  1  |A| == |B|
- far_path_o  output  1  select far path
- nan_o  output  1  result is NaN
- inf_o  output  1  result is infinity
- nv_o  output  1  invalid flag
- rm_o  output  3  registered rm_i

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all valids and all data/flag outputs are 0.
- Pipeline:
  - S1 register captures opa, opb, is_sub, rm, and a 15-bit magnitude compare (a_ge = opa[14:0] >= opb[14:0], a_eq).
  - S2 register captures all outputs.
  - Latency is 2 cycles from accept to out_valid_o. Throughput is 1 beat/cycle.
- Handshake:
  - s2_en = !s2_valid | out_ready_i.
  - s1_en = !s1_valid | s2_en.
  - in_ready_o = s1_en (combinational from out_ready_i is allowed).
  - Accept occurs when in_valid_i & in_ready_o.
  - Outputs are held stable while out_valid_o & !out_ready_i.
  - No beat is dropped or duplicated.
- flush_i: clears s1_valid and s2_valid next edge. in_ready_o is forced 0 that cycle. An input offered in the flush cycle is not accepted.
- Arithmetic (S2):
  - sign_b_eff = opb[15] ^ is_sub.
  - swap = !a_ge; the large operand is B when swap.
  - do_sub = opa[15] ^ sign_b_eff.
  - exp_diff = exp_large - exp_small, 5-bit. It never underflows because of the ordering. Max is 31.
  - sign_res = swap ? sign_b_eff : opa[15].
  - far_path = !do_sub | (exp_diff > 1).
  - eq_mag = a_eq.
- Denormals: hidden bit is 0 when exp == 0. exp_diff stays raw. Denormal correction is downstream's job.
- Specials (exp == 31):
  - nan_o = either operand NaN, or (both inf & do_sub).
  - nv_o = any sNaN (mant[9] == 0, mant != 0), or (inf - inf).
  - inf_o = any inf & !nan_o.
  - Other outputs are don't-care but deterministic per the formulas above.
- Reset asserted mid-transfer: all in-flight beats are lost and outputs return to 0 immediately (async).
- Simultaneous flush_i and out_ready_i: the flush wins. The S2 beat is still considered consumed if out_valid_o was high.

Test Plan:
- opa=0x3C00, opb=0x4000, add -> after 2 cycles: swap, exp_diff=1, do_sub=0, exp_large=16, sig_large=0x400, sig_small=0x400, sign_res=0, far_path=1.
- opa=0x3C00, opb=0x3800, is_sub=1 -> do_sub=1, exp_diff=1, far_path=0, sign_res=0, exp_large=15.
- opa=0x0001, opb=0x3C00, add -> exp_diff=15, exp_zero=1, sig_small=0x001, sig_large=0x400, far_path=1.
- opa=0x7C00, opb=0x7C00, is_sub=1 -> nan_o=1, nv_o=1, inf_o=0. opa=0x7D00 (sNaN) + 0x3C00 -> nan_o=1, nv_o=1.
- Backpressure: 4 back-to-back beats with out_ready_i=0 -> 2 beats accepted, in_ready_o=0 from 3rd cycle, outputs stable. Then out_ready_i=1 -> all 4 beats emerge in order, no loss.
- flush_i pulse with 2 beats in flight -> out_valid_o=0 next cycle. Then assert rst_n=0 mid-stream -> all outputs 0 asynchronously.
